barrel_shifter_pipe: RTL and testbench

//  Parametrised, fully pipelined barrel shifter for the ALU datapath: arithmetic/logical shifts plus rotates.
//  One log2 shift stage per register, so one operation is accepted per clock.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_stage.sv | 77 +++++++
 rtl/barrel_shifter_pipe.sv | 60 ++++++
 tb/tb_barrel_shifter_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared opcode encodings and the per-stage control payload for the pipelined barrel shifter.
package shifter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SRA  = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b010;
    localparam logic [OP_W-1:0] OP_SLLA = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b101;

    // Width-independent part of the stage payload; data and rem_b travel beside it.
    typedef struct packed {
        logic            valid;
        logic [OP_W-1:0] op;
        logic            sign;
        logic            carry;
    } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shift/rotate by STEP under control of b bit log2(STEP), then register.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  stage_ctrl_t       i_ctrl,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [SHW-1:0]    i_rem_b,
    output stage_ctrl_t       o_ctrl,
    output logic [WIDTH-1:0]  o_data,
    output logic [SHW-1:0]    o_rem_b
);

    localparam int               IDX       = $clog2(STEP);
    localparam logic [WIDTH-1:0] SIGN_FILL = ~({WIDTH{1'b1}} >> STEP);

    stage_ctrl_t      w_ctrl;
    logic [WIDTH-1:0] w_data;

    stage_ctrl_t      r_ctrl;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_rem_b;

    // Carry is the last bit to leave the word, so it only moves in stages that actually shift.
    always_comb begin
        w_ctrl = i_ctrl;
        w_data = i_data;
        if (i_rem_b[IDX]) begin
            case (i_ctrl.op)
                OP_SRA: begin
                    w_data       = (i_data >> STEP) | ({WIDTH{i_ctrl.sign}} & SIGN_FILL);
                    w_ctrl.carry = i_data[STEP-1];
                end
                OP_SRL: begin
                    w_data       = i_data >> STEP;
                    w_ctrl.carry = i_data[STEP-1];
                end
                OP_SLL, OP_SLLA: begin
                    w_data       = i_data << STEP;
                    w_ctrl.carry = i_data[WIDTH-STEP];
                end
                OP_ROR: begin
                    w_data       = (i_data >> STEP) | (i_data << (WIDTH - STEP));
                    w_ctrl.carry = 1'b0;
                end
                OP_ROL: begin
                    w_data       = (i_data << STEP) | (i_data >> (WIDTH - STEP));
                    w_ctrl.carry = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl  <= '0;
            r_data  <= '0;
            r_rem_b <= '0;
        end else if (i_en) begin
            r_ctrl  <= w_ctrl;
            r_data  <= w_data;
            r_rem_b <= i_rem_b;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_rem_b = r_rem_b;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Fully pipelined barrel shifter (one log2 step per stage) with a global valid/ready stall.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int OPW   = OP_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [SHW-1:0]    i_b,
    input  logic [OPW-1:0]    i_aluc,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [WIDTH-1:0]  o_c,
    output logic              o_carry,
    output logic              o_zero
);

    stage_ctrl_t      w_ctrl  [SHW+1];
    logic [WIDTH-1:0] w_data  [SHW+1];
    logic [SHW-1:0]   w_rem_b [SHW+1];
    logic             w_advance;

    // The whole pipe moves as one; bubbles are carried, never squeezed out.
    assign w_advance  = !w_ctrl[SHW].valid || i_out_ready;
    assign o_in_ready = w_advance;

    assign w_ctrl[0]  = '{valid: i_in_valid, op: i_aluc, sign: i_a[WIDTH-1], carry: 1'b0};
    assign w_data[0]  = i_a;
    assign w_rem_b[0] = i_b;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .STEP  (1 << k)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_advance),
            .i_ctrl  (w_ctrl[k]),
            .i_data  (w_data[k]),
            .i_rem_b (w_rem_b[k]),
            .o_ctrl  (w_ctrl[k+1]),
            .o_data  (w_data[k+1]),
            .o_rem_b (w_rem_b[k+1])
        );
    end

    assign o_out_valid = w_ctrl[SHW].valid;
    assign o_c         = w_data[SHW];
    assign o_carry     = w_ctrl[SHW].carry;
    // Qualified by valid so an empty pipe after reset does not flag zero.
    assign o_zero      = w_ctrl[SHW].valid && (w_data[SHW] == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: driver pushes reference results, monitor pops on output transfers.
module tb_barrel_shifter_pipe;
    import shifter_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [SHW-1:0]    b = '0;
    logic [2:0]        aluc = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  c;
    logic              carry;
    logic              zero;

    barrel_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW), .OPW(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_aluc      (aluc),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_c         (c),
        .o_carry     (carry),
        .o_zero      (zero)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit lat_mode = 1'b1;
    bit done     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] c;
        logic        carry;
        logic        zero;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the original operand and shift amount.
    function automatic void ref_model(input logic [31:0] ra, input logic [4:0] rb,
                                      input logic [2:0] op,
                                      output logic [31:0] rc, output logic rcarry);
        int          n;
        logic [63:0] dbl;
        logic [63:0] tmp;
        n      = int'(rb);
        dbl    = {ra, ra};
        rcarry = 1'b0;
        case (op)
            3'b000: begin
                rc = $signed(ra) >>> n;
                if (n > 0) rcarry = ra[n-1];
            end
            3'b001: begin
                rc = ra >> n;
                if (n > 0) rcarry = ra[n-1];
            end
            3'b010, 3'b011: begin
                rc = ra << n;
                if (n > 0) rcarry = ra[32-n];
            end
            3'b100: begin
                tmp = dbl >> n;
                rc  = tmp[31:0];
            end
            3'b101: begin
                tmp = dbl << n;
                rc  = tmp[63:32];
            end
            default: rc = ra;
        endcase
    endfunction

    // Holds the operation on the inputs until it is accepted; called at posedge+1.
    task automatic issue(input logic [31:0] ia, input logic [4:0] ib, input logic [2:0] op,
                         input logic [31:0] ec, input logic ecarry);
        int waited;
        bit acc;
        waited   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        aluc     = op;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc)
                sb.push_back('{c: ec, carry: ecarry, zero: (ec == 32'h0), cyc: cyc, lat: lat_mode});
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
                    acc = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        aluc     = 'x;
    endtask

    task automatic issue_m(input logic [31:0] ia, input logic [4:0] ib, input logic [2:0] op);
        logic [31:0] ec;
        logic        ecarry;
        ref_model(ia, ib, op, ec, ecarry);
        issue(ia, ib, op, ec, ecarry);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", sb.size(), 0);
    endtask

    // Monitor
    exp_t        e;
    logic [31:0] prev_c;
    bit          stalled = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (out_valid) begin
                if (stalled) chk("hold_c", c, prev_c);
                if (!out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    stalled = 1'b1;
                    prev_c  = c;
                end else begin
                    stalled = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got c=%h with empty scoreboard", c);
                    end else begin
                        e = sb.pop_front();
                        chk("c", c, e.c);
                        chk("carry", carry, e.carry);
                        chk("zero", zero, e.zero);
                        if (e.lat) chk("latency", cyc - e.cyc, SHW);
                    end
                end
            end else begin
                stalled = 1'b0;
                chk("idle_in_ready", in_ready, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill part of the pipe, then reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) issue_m($urandom, 5'($urandom), OP_SRL);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_c", c, 0);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Modes
        issue(32'hA5F0C3E7, 5'd4, OP_SRA, 32'hFA5F0C3E, 1'b0);
        issue(32'hA5F0C3E7, 5'd4, OP_SRL, 32'h0A5F0C3E, 1'b0);
        issue(32'hA5F0C3E7, 5'd4, OP_SLL, 32'h5F0C3E70, 1'b0);
        issue(32'hA5F0C3E7, 5'd4, OP_ROR, 32'h7A5F0C3E, 1'b0);
        issue(32'hA5F0C3E7, 5'd4, OP_ROL, 32'h5F0C3E7A, 1'b0);

        // Boundaries
        for (int i = 0; i < 8; i++) issue(32'hA5F0C3E7, 5'd0, 3'(i), 32'hA5F0C3E7, 1'b0);
        issue(32'hA5F0C3E7, 5'd31, OP_SRA, 32'hFFFFFFFF, 1'b0);
        issue(32'h80000000, 5'd31, OP_SRL, 32'h00000001, 1'b0);
        issue(32'h00000001, 5'd31, OP_SLL, 32'h80000000, 1'b0);
        issue(32'h00000000, 5'd3,  OP_SRL, 32'h00000000, 1'b0);
        issue(32'h40000000, 5'd2,  OP_SLL, 32'h00000000, 1'b1);
        drain();
        idle(1);

        // Back-to-back throughput
        for (int i = 0; i < 32; i++) issue_m($urandom, 5'(i), OP_SRL);
        drain();
        idle(1);

        // Backpressure on a full pipe
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) issue_m($urandom, 5'($urandom), 3'($urandom_range(0, 5)));
            end
            begin
                idle(8);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        drain();
        idle(1);

        // Reserved ops and random traffic with gaps and random consumer stalls
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
                    else                           op = {2'b11, 1'($urandom_range(0, 1))};
                    issue_m($urandom, 5'($urandom), op);
                    idle($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
